// File: rtl/hdc_class_trainer_if.sv
// hdc_class_trainer_if: labelled HV beat input stream and thresholded class-vector output stream
interface hdc_class_trainer_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_bits;
  logic         in_label;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bits;
  logic         out_class;
  logic         out_last;
  modport master (
    output in_valid, in_bits, in_label, in_last, out_ready,
    input  in_ready, out_valid, out_bits, out_class, out_last
  );
  modport slave (
    input  in_valid, in_bits, in_label, in_last, out_ready,
    output in_ready, out_valid, out_bits, out_class, out_last
  );
endinterface

// File: rtl/hdc_class_trainer.sv
// hdc_class_trainer: bundles labelled bipolar HVs into per-class saturating accumulators and drains thresholded class HVs
module hdc_class_trainer #(
  parameter int DIM   = 10000,
  parameter int W     = 32,
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hdc_class_trainer_if.slave bus,
  input  logic             finalize,
  input  logic             acc_clr,
  output logic             busy,
  output logic             err_len,
  output logic [CNT_W-1:0] n_ham,
  output logic [CNT_W-1:0] n_spam
);
  localparam int NB = (DIM + W - 1) / W;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST = BW'(NB - 1);
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = -MAXV;
  typedef enum logic [1:0] {CLEAR, IDLE, DRAIN} state_t;
  state_t state, state_d;
  logic [BW-1:0] clr_idx, clr_idx_d, beat_cnt, beat_cnt_d, dbeat, dbeat_d;
  logic lbl_q, lbl_q_d, dcls, dcls_d, err_d;
  logic [CNT_W-1:0] n_ham_d, n_spam_d;
  logic signed [ACC_W-1:0] acc [2][NB][W];
  logic signed [ACC_W-1:0] row_nxt [W];
  logic lbl, fire, at_end;
  logic [W-1:0] thr;
  // beat 0 carries the label directly; later beats use the latched copy
  assign lbl           = beat_cnt == '0 ? bus.in_label : lbl_q;
  assign bus.in_ready  = state == IDLE && !finalize && !acc_clr;
  assign fire          = bus.in_valid && bus.in_ready;
  assign at_end        = beat_cnt == LAST;
  assign bus.out_valid = state == DRAIN;
  assign bus.out_class = bus.out_valid && dcls;
  assign bus.out_last  = bus.out_valid && dbeat == LAST;
  assign bus.out_bits  = bus.out_valid ? thr : '0;
  assign busy          = state != IDLE;
  always_comb begin
    for (int k = 0; k < W; k++)
      row_nxt[k] = bus.in_bits[k]
        ? (acc[lbl][beat_cnt][k] == MAXV ? MAXV : acc[lbl][beat_cnt][k] + ACC_W'(1))
        : (acc[lbl][beat_cnt][k] == MINV ? MINV : acc[lbl][beat_cnt][k] - ACC_W'(1));
  end
  // zero sums break ties toward 1 on even dimensions; padding dims read as 0
  always_comb begin
    thr = '0;
    for (int k = 0; k < W; k++)
      thr[k] = (int'(dbeat) * W + k < DIM) &&
               (acc[dcls][dbeat][k][ACC_W-1] ? 1'b0
                : (acc[dcls][dbeat][k] != '0 || (int'(dbeat) * W + k) % 2 == 0));
  end
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      for (int k = 0; k < W; k++) begin
        acc[0][clr_idx][k] <= '0;
        acc[1][clr_idx][k] <= '0;
      end
    else if (fire)
      for (int k = 0; k < W; k++)
        if (int'(beat_cnt) * W + k < DIM) acc[lbl][beat_cnt][k] <= row_nxt[k];
  end
  always_comb begin
    state_d    = state;
    clr_idx_d  = clr_idx;
    beat_cnt_d = beat_cnt;
    lbl_q_d    = lbl_q;
    dcls_d     = dcls;
    dbeat_d    = dbeat;
    err_d      = err_len;
    n_ham_d    = n_ham;
    n_spam_d   = n_spam;
    if (state == CLEAR) begin
      clr_idx_d = clr_idx == LAST ? '0 : clr_idx + BW'(1);
      state_d   = clr_idx == LAST ? IDLE : CLEAR;
    end else if (acc_clr) begin
      state_d    = CLEAR;
      clr_idx_d  = '0;
      beat_cnt_d = '0;
      err_d      = 1'b0;
      n_ham_d    = '0;
      n_spam_d   = '0;
    end else if (state == DRAIN) begin
      if (bus.out_ready) begin
        dbeat_d = dbeat == LAST ? '0 : dbeat + BW'(1);
        if (dbeat == LAST) begin
          dcls_d  = !dcls;
          state_d = dcls ? IDLE : DRAIN;
        end
      end
    end else if (finalize) begin
      if (beat_cnt == '0) begin
        state_d = DRAIN;
        dcls_d  = 1'b0;
        dbeat_d = '0;
      end
    end else if (fire) begin
      lbl_q_d    = lbl;
      beat_cnt_d = (bus.in_last || at_end) ? '0 : beat_cnt + BW'(1);
      if (bus.in_last && at_end) begin
        n_ham_d  = (!lbl && !(&n_ham)) ? n_ham + CNT_W'(1) : n_ham;
        n_spam_d = (lbl && !(&n_spam)) ? n_spam + CNT_W'(1) : n_spam;
      end else if (bus.in_last || at_end) begin
        err_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      beat_cnt <= '0;
      lbl_q    <= 1'b0;
      dcls     <= 1'b0;
      dbeat    <= '0;
      err_len  <= 1'b0;
      n_ham    <= '0;
      n_spam   <= '0;
    end else begin
      state    <= state_d;
      clr_idx  <= clr_idx_d;
      beat_cnt <= beat_cnt_d;
      lbl_q    <= lbl_q_d;
      dcls     <= dcls_d;
      dbeat    <= dbeat_d;
      err_len  <= err_d;
      n_ham    <= n_ham_d;
      n_spam   <= n_spam_d;
    end
  end
endmodule

// File: tb/tb_hdc_class_trainer.sv
// tb_hdc_class_trainer: scoreboard bench for hdc_class_trainer at DIM=40, W=32, ACC_W=4
module tb_hdc_class_trainer;
  localparam int DIM = 40, W = 32, ACC_W = 4, CNT_W = 16, NB = 2, AMAX = 7;
  logic clk = 1'b0, rst_n = 1'b0, finalize = 1'b0, acc_clr = 1'b0;
  logic busy, err_len;
  logic [CNT_W-1:0] n_ham, n_spam;
  hdc_class_trainer_if #(.W(W)) bus ();
  hdc_class_trainer #(.DIM(DIM), .W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .finalize(finalize), .acc_clr(acc_clr),
    .busy(busy), .err_len(err_len), .n_ham(n_ham), .n_spam(n_spam)
  );
  always #5 clk = ~clk;
  int checks = 0, passes = 0, hs_cnt = 0;
  logic [W+1:0] exp_q[$];
  int macc[2][DIM];
  int mbeat;
  bit mlbl;
  // output scoreboard: every handshake is compared against the next expected beat
  always @(negedge clk) begin : mon
    logic [W+1:0] got, e;
    if (bus.out_valid && bus.out_ready) begin
      got = {bus.out_bits, bus.out_class, bus.out_last};
      hs_cnt++;
      checks++;
      if (exp_q.size() == 0) $display("FAIL drain_extra got %h exp none", got);
      else begin
        e = exp_q.pop_front();
        if (got !== e) $display("FAIL drain_beat got %h exp %h", got, e);
        else passes++;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic model_clear();
    foreach (macc[c, d]) macc[c][d] = 0;
    mbeat = 0;
    mlbl = 1'b0;
  endtask
  task automatic push_expect();
    logic [W-1:0] b;
    int d;
    for (int c = 0; c < 2; c++)
      for (int bt = 0; bt < NB; bt++) begin
        b = '0;
        for (int k = 0; k < W; k++) begin
          d = bt * W + k;
          if (d < DIM) b[k] = macc[c][d] > 0 ? 1'b1 : macc[c][d] < 0 ? 1'b0 : (d % 2 == 0);
        end
        exp_q.push_back({b, c[0], bt == NB - 1});
      end
  endtask
  task automatic send_beat(input logic [W-1:0] bits, input bit label, input bit last);
    bit l;
    int d;
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.in_bits = bits; bus.in_label = label; bus.in_last = last;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL in_ready got %b exp 1", bus.in_ready);
    else passes++;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    l = mbeat == 0 ? label : mlbl;
    mlbl = l;
    for (int k = 0; k < W; k++) begin
      d = mbeat * W + k;
      if (d < DIM)
        macc[l][d] = bits[k] ? (macc[l][d] < AMAX ? macc[l][d] + 1 : AMAX)
                             : (macc[l][d] > -AMAX ? macc[l][d] - 1 : -AMAX);
    end
    mbeat = (last || mbeat == NB - 1) ? 0 : mbeat + 1;
  endtask
  task automatic send_msg(input logic [W-1:0] bits, input bit label);
    send_beat(bits, label, 1'b0);
    send_beat(bits, label, 1'b1);
  endtask
  task automatic do_clear();
    int n = 0;
    @(posedge clk); #2 acc_clr = 1'b1;
    @(posedge clk); #2 acc_clr = 1'b0;
    do begin @(negedge clk); n++; end while (busy && n < 20);
    checks++;
    if (busy !== 1'b0) $display("FAIL clear_done got busy=%b exp 0", busy);
    else passes++;
    model_clear();
  endtask
  task automatic start_drain();
    push_expect();
    @(posedge clk); #2 finalize = 1'b1;
    @(posedge clk); #2 finalize = 1'b0;
  endtask
  task automatic run_drain(input bit stall);
    int h0, n;
    bit done;
    logic [W+2:0] snap;
    h0 = hs_cnt; n = 0; done = 1'b0;
    bus.out_ready = 1'b1;
    start_drain();
    while (exp_q.size() > 0 && n < 200) begin
      if (stall && !done && hs_cnt - h0 == 1) begin
        done = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        snap = {bus.out_valid, bus.out_bits, bus.out_class, bus.out_last};
        repeat (4) begin
          @(negedge clk);
          checks++;
          if ({bus.out_valid, bus.out_bits, bus.out_class, bus.out_last} !== snap)
            $display("FAIL stall_hold got %h exp %h", {bus.out_valid, bus.out_bits, bus.out_class, bus.out_last}, snap);
          else passes++;
        end
        @(posedge clk); #2 bus.out_ready = 1'b1;
      end
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) $display("FAIL drain_timeout got %0d left exp 0", exp_q.size());
    else passes++;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL drain_end got busy=%b out_valid=%b exp 0 0", busy, bus.out_valid);
    else passes++;
    checks++;
    if (hs_cnt - h0 != 2 * NB) $display("FAIL handshakes got %0d exp %0d", hs_cnt - h0, 2 * NB);
    else passes++;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || n_ham !== 0 || n_spam !== 0)
      $display("FAIL reset_hold got in_ready=%b out_valid=%b n=%0d/%0d exp 0 0 0/0", bus.in_ready, bus.out_valid, n_ham, n_spam);
    else passes++;
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL reset_clear%0d got busy=%b in_ready=%b exp 1 0", i, busy, bus.in_ready);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b1 || n_ham !== 0 || n_spam !== 0 || err_len !== 1'b0)
      $display("FAIL reset_idle got busy=%b in_ready=%b n=%0d/%0d err=%b exp 0 1 0/0 0", busy, bus.in_ready, n_ham, n_spam, err_len);
    else passes++;
    model_clear();
  endtask
  task automatic test_bundle();
    send_msg('1, 1'b0);
    send_msg('1, 1'b0);
    send_msg('0, 1'b0);
    @(negedge clk);
    checks++;
    if (n_ham !== 3 || n_spam !== 0 || err_len !== 1'b0)
      $display("FAIL bundle_counts got %0d/%0d err=%b exp 3/0 0", n_ham, n_spam, err_len);
    else passes++;
    run_drain(1'b0);
  endtask
  task automatic test_saturate();
    do_clear();
    repeat (9) send_msg('1, 1'b1);
    send_msg('0, 1'b1);
    @(negedge clk);
    checks++;
    if (n_spam !== 10 || n_ham !== 0) $display("FAIL sat_counts got %0d/%0d exp 0/10", n_ham, n_spam);
    else passes++;
    run_drain(1'b0);
  endtask
  task automatic test_len_err();
    do_clear();
    send_beat('1, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (err_len !== 1'b1 || n_ham !== 0) $display("FAIL early_last got err=%b n_ham=%0d exp 1 0", err_len, n_ham);
    else passes++;
    send_msg(32'hA5A5_0F0F, 1'b1);
    @(negedge clk);
    checks++;
    if (n_spam !== 1 || n_ham !== 0) $display("FAIL after_err got %0d/%0d exp 0/1", n_ham, n_spam);
    else passes++;
    do_clear();
    checks++;
    if (err_len !== 1'b0 || n_spam !== 0) $display("FAIL clr_err got err=%b n_spam=%0d exp 0 0", err_len, n_spam);
    else passes++;
    send_beat(32'h0F0F_F0F0, 1'b1, 1'b0);
    send_beat(32'h0F0F_F0F0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (err_len !== 1'b1 || n_spam !== 0) $display("FAIL missing_last got err=%b n_spam=%0d exp 1 0", err_len, n_spam);
    else passes++;
    send_msg(32'h1234_5678, 1'b0);
    @(negedge clk);
    checks++;
    if (n_ham !== 1 || n_spam !== 0) $display("FAIL len_counts got %0d/%0d exp 1/0", n_ham, n_spam);
    else passes++;
  endtask
  task automatic test_stall();
    run_drain(1'b1);
  endtask
  task automatic test_clr_drain();
    int h0, n;
    send_msg('1, 1'b1);
    h0 = hs_cnt; n = 0;
    bus.out_ready = 1'b1;
    start_drain();
    while (hs_cnt == h0 && n < 20) begin @(posedge clk); #2; n++; end
    checks++;
    if (hs_cnt - h0 != 1) $display("FAIL clr_first_beat got %0d exp 1", hs_cnt - h0);
    else passes++;
    bus.out_ready = 1'b0;
    acc_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL clr_pre got out_valid=%b exp 1", bus.out_valid);
    else passes++;
    @(posedge clk); #2 acc_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b1)
        $display("FAIL clr_abort%0d got out_valid=%b busy=%b exp 0 1", i, bus.out_valid, busy);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_ham !== 0 || n_spam !== 0)
      $display("FAIL clr_idle got busy=%b n=%0d/%0d exp 0 0/0", busy, n_ham, n_spam);
    else passes++;
    exp_q.delete();
    model_clear();
    run_drain(1'b0);
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.in_bits = '0; bus.in_label = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_bundle();
    test_saturate();
    test_len_err();
    test_stall();
    test_clr_drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
